// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulator readout sequencer.
// The FSM states, default serial frame length and frame-tag width live here.
package acc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int SHIFT_LEN_DEFAULT = 32;
  localparam int FRAME_TAG_W       = 8;

endpackage

// File: rtl/acc_seq_shift_timer.sv
// Serial frame timer: a load starts a frame of SHIFT_LEN shift cycles that begin
// on the following cycle; busy covers the load cycle plus every shift cycle.
module acc_seq_shift_timer
  import acc_seq_pkg::*;
#(
  parameter int SHIFT_LEN = SHIFT_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic shift,
  output logic busy
);

  localparam int CNT_W = $clog2(SHIFT_LEN + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(SHIFT_LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign shift = (cnt_q != '0);
  assign busy  = load | shift;

endmodule

// File: rtl/acc_readout_sequencer.sv
// Accumulation-window sequencer: clear, accumulate for windowLength cycles, snapshot
// and start the serializer. Optional frame counter enabled by ACC_SEQ_FRAME_TAG_EN.
module acc_readout_sequencer
  import acc_seq_pkg::*;
#(
  parameter int WINDOW_WIDTH = 20,
  parameter int SHIFT_LEN    = SHIFT_LEN_DEFAULT
) (
  input  logic                    accumulatorClk,
  input  logic                    accumulatorResetN,
  input  logic                    runEnable,
  input  logic                    singleShot,
  input  logic [WINDOW_WIDTH-1:0] windowLength,
  input  logic                    overrunClear,
  output logic                    accClear,
  output logic                    accEnable,
  output logic                    snapshotLoad,
  output logic                    serialStart,
  output logic                    serialShift,
  output logic                    serialBusy,
  output logic                    overrun,
  output logic [FRAME_TAG_W-1:0]  frameTag
);

  state_t                  state_q, state_d;
  logic [WINDOW_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic                    boundary_q, boundary_d;
  logic                    overrun_q, overrun_d;
  logic [WINDOW_WIDTH-1:0] eff_len;
  logic                    boundary_hit;

  // A zero-length window would never flag a boundary, so it runs as one cycle.
  assign eff_len      = (windowLength == '0) ? WINDOW_WIDTH'(1) : windowLength;
  assign boundary_hit = (state_q == ST_ACCUM) && boundary_q;

  always_ff @(posedge accumulatorClk or negedge accumulatorResetN) begin
    if (!accumulatorResetN) begin
      state_q    <= ST_IDLE;
      win_cnt_q  <= '0;
      boundary_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      boundary_q <= boundary_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    boundary_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (runEnable) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!runEnable) begin
          state_d = ST_IDLE;
        end else begin
          win_cnt_d = eff_len;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (boundary_q) begin
          if (singleShot || !runEnable) begin
            state_d = ST_STOP;
          end else begin
            win_cnt_d = eff_len;
          end
        end else if (!runEnable) begin
          state_d   = ST_IDLE;
          win_cnt_d = '0;
        end else if (win_cnt_q == WINDOW_WIDTH'(1)) begin
          boundary_d = 1'b1;
          win_cnt_d  = '0;
        end else begin
          win_cnt_d = win_cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (!runEnable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A window ending on a busy serializer wins over a simultaneous clear.
    overrun_d = overrun_q;
    if (boundary_hit && serialShift) begin
      overrun_d = 1'b1;
    end else if (overrunClear) begin
      overrun_d = 1'b0;
    end
  end

  // serialShift (not serialBusy) gates the snapshot to avoid a loop through load.
  always_comb begin
    accClear     = 1'b0;
    accEnable    = 1'b0;
    snapshotLoad = 1'b0;
    unique case (state_q)
      ST_CLEAR: accClear = 1'b1;
      ST_ACCUM: begin
        accEnable    = !boundary_q;
        accClear     = boundary_q;
        snapshotLoad = boundary_q && !serialShift;
      end
      default: ;
    endcase
  end

  assign serialStart = snapshotLoad;
  assign overrun     = overrun_q;

  acc_seq_shift_timer #(
    .SHIFT_LEN(SHIFT_LEN)
  ) u_shift_timer (
    .clk  (accumulatorClk),
    .rst_n(accumulatorResetN),
    .load (snapshotLoad),
    .shift(serialShift),
    .busy (serialBusy)
  );

`ifdef ACC_SEQ_FRAME_TAG_EN
  logic [FRAME_TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    tag_d = snapshotLoad ? tag_q + 1'b1 : tag_q;
  end

  always_ff @(posedge accumulatorClk or negedge accumulatorResetN) begin
    if (!accumulatorResetN) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign frameTag = tag_q;
`else
  assign frameTag = '0;
`endif

endmodule

// File: tb/tb_acc_readout_sequencer.sv
// Directed bench for acc_readout_sequencer; cycle 1 is the CLEAR cycle after runEnable
// is first sampled high. Observed vector: {clr,en,load,start,shift,busy,ovr}.
module tb_acc_readout_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        ss;
  logic [19:0] wl;
  logic        ovc;
  logic        acc_clear, acc_enable, snap_load, ser_start, ser_shift, ser_busy, ovr;
  logic [7:0]  tag;
  logic [6:0]  obs;
  logic [6:0]  exp_v;

  int tests_run;
  int tests_failed;

`ifdef ACC_SEQ_FRAME_TAG_EN
  localparam int TAG_ON = 1;
`else
  localparam int TAG_ON = 0;
`endif

  acc_readout_sequencer #(
    .WINDOW_WIDTH(20),
    .SHIFT_LEN(32)
  ) dut (
    .accumulatorClk   (clk),
    .accumulatorResetN(rst_n),
    .runEnable        (run),
    .singleShot       (ss),
    .windowLength     (wl),
    .overrunClear     (ovc),
    .accClear         (acc_clear),
    .accEnable        (acc_enable),
    .snapshotLoad     (snap_load),
    .serialStart      (ser_start),
    .serialShift      (ser_shift),
    .serialBusy       (ser_busy),
    .overrun          (ovr),
    .frameTag         (tag)
  );

  assign obs = {acc_clear, acc_enable, snap_load, ser_start, ser_shift, ser_busy, ovr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    ss    = 1'b0;
    ovc   = 1'b0;
    wl    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    ss    = 1'b0;
    ovc   = 1'b0;
    wl    = 20'd7;
    #1;
    tests_run++;
    if ({obs, tag} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b/%h expected 0/00", obs, tag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({obs, tag} !== 15'd0) begin
      tests_failed++;
      $display("FAIL idle_no_run: got %b/%h expected 0/00", obs, tag);
    end
  endtask

  task automatic test_continuous_l40();
    logic clr, en, bnd, sh;
    do_reset();
    wl  = 20'd40;
    run = 1'b1;
    tick();
    for (int c = 1; c <= 160; c++) begin
      bnd   = (c >= 2) && (((c - 2) % 41) == 40);
      en    = (c >= 2) && (((c - 2) % 41) < 40);
      clr   = (c == 1) || bnd;
      sh    = (c >= 43) && (((c - 43) % 41) < 32);
      exp_v = {clr, en, bnd, bnd, sh, bnd | sh, 1'b0};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL cont_l40 cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      tick();
    end
    tests_run++;
    if (tag !== ((TAG_ON != 0) ? 8'd3 : 8'd0)) begin
      tests_failed++;
      $display("FAIL cont_l40_tag: got %0d expected %0d", tag, (TAG_ON != 0) ? 3 : 0);
    end
  endtask

  task automatic test_overrun_l31();
    do_reset();
    wl  = 20'd31;
    run = 1'b1;
    tick();
    for (int c = 1; c <= 131; c++) begin
      if (c == 33 || c == 97) begin
        tests_run++;
        if ({acc_clear, snap_load, ser_start} !== 3'b111) begin
          tests_failed++;
          $display("FAIL ovr31_snap cycle %0d: got clr/load/start %b expected 111", c,
                   {acc_clear, snap_load, ser_start});
        end
      end
      if (c == 65 || c == 129) begin
        tests_run++;
        if ({acc_clear, snap_load, ser_busy} !== 3'b101) begin
          tests_failed++;
          $display("FAIL ovr31_suppress cycle %0d: got clr/load/busy %b expected 101", c,
                   {acc_clear, snap_load, ser_busy});
        end
      end
      if (c == 64 || c == 66 || c == 97 || c == 101 || c == 130) begin
        tests_run++;
        if (ovr !== ((c == 64 || c == 101) ? 1'b0 : 1'b1)) begin
          tests_failed++;
          $display("FAIL ovr31_flag cycle %0d: got %b expected %b", c, ovr,
                   (c == 64 || c == 101) ? 1'b0 : 1'b1);
        end
      end
      if (c == 98) begin
        tests_run++;
        if (tag !== ((TAG_ON != 0) ? 8'd2 : 8'd0)) begin
          tests_failed++;
          $display("FAIL ovr31_tag: got %0d expected %0d", tag, (TAG_ON != 0) ? 2 : 0);
        end
      end
      ovc = (c == 100) || (c == 129);
      tick();
    end
    ovc = 1'b0;
  endtask

  task automatic test_single_shot();
    logic clr, en, ld, sh, bsy;
    do_reset();
    wl  = 20'd5;
    ss  = 1'b1;
    run = 1'b1;
    tick();
    for (int c = 1; c <= 50; c++) begin
      ld    = (c == 7);
      clr   = (c == 1) || ld;
      en    = (c >= 2) && (c <= 6);
      sh    = (c >= 8) && (c <= 39);
      bsy   = (c >= 7) && (c <= 39);
      exp_v = {clr, en, ld, ld, sh, bsy, 1'b0};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL single_shot cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      tick();
    end
    run = 1'b0;
    tick();
    tests_run++;
    if (obs !== 7'd0) begin
      tests_failed++;
      $display("FAIL single_shot_idle: got %b expected 0000000", obs);
    end
    run = 1'b1;
    tick();
    tests_run++;
    if ({acc_clear, acc_enable} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_shot_restart_clear: got clr/en %b expected 10", {acc_clear, acc_enable});
    end
    tick();
    tests_run++;
    if ({acc_clear, acc_enable} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_shot_restart_accum: got clr/en %b expected 01", {acc_clear, acc_enable});
    end
  endtask

  task automatic test_abort();
    logic clr, en, ld, sh, bsy;
    do_reset();
    wl  = 20'd10;
    run = 1'b1;
    tick();
    for (int c = 1; c <= 50; c++) begin
      ld    = (c == 12);
      clr   = (c == 1) || ld;
      en    = ((c >= 2) && (c <= 11)) || ((c >= 13) && (c <= 15));
      sh    = (c >= 13) && (c <= 44);
      bsy   = (c >= 12) && (c <= 44);
      exp_v = {clr, en, ld, ld, sh, bsy, 1'b0};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL abort cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      run = (c < 15);
      tick();
    end
  endtask

  task automatic test_zero_len();
    logic clr, en, bnd, ld;
    do_reset();
    wl  = 20'd0;
    run = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      en    = (c >= 2) && ((c % 2) == 0);
      bnd   = (c >= 3) && ((c % 2) == 1);
      clr   = (c == 1) || bnd;
      ld    = (c == 3);
      exp_v = {clr, en, ld, ld, (c >= 4), (c >= 3), (c >= 6)};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL zero_len cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    wl  = 20'd40;
    run = 1'b1;
    tick();
    repeat (49) tick();
    tests_run++;
    if ({ser_shift, ser_busy, tag} !== {2'b11, (TAG_ON != 0) ? 8'd1 : 8'd0}) begin
      tests_failed++;
      $display("FAIL mid_shift_pre: got shift/busy %b tag %0d expected 11 tag %0d",
               {ser_shift, ser_busy}, tag, (TAG_ON != 0) ? 1 : 0);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({obs, tag} !== 15'd0) begin
      tests_failed++;
      $display("FAIL mid_shift_async_reset: got %b/%h expected 0/00", obs, tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({acc_clear, acc_enable, ser_shift} !== 3'b100) begin
      tests_failed++;
      $display("FAIL mid_shift_restart_clear: got clr/en/shift %b expected 100",
               {acc_clear, acc_enable, ser_shift});
    end
    tick();
    tests_run++;
    if ({acc_clear, acc_enable} !== 2'b01) begin
      tests_failed++;
      $display("FAIL mid_shift_restart_accum: got clr/en %b expected 01", {acc_clear, acc_enable});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_continuous_l40();
    test_overrun_l31();
    test_single_shot();
    test_abort();
    test_zero_len();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
